present_enc_iter: RTL
=====================

Name: present_enc_iter

Overview:
- Iterative PRESENT-80 encryption core: one round per clock, built around the existing `permutation` module and a new S-box layer.
- Holds the 64-bit cipher state and the 80-bit key register.
- Generates round keys on the fly.
- Performs the final key whitening and hands the ciphertext out with a valid pulse.
- Sits between the bus/host interface (plaintext/key source) and the downstream ciphertext consumer.

Parameters:
- ROUNDS, 31, number of full rounds; reduced values are for debug/test only; legal range 1..31.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  reset; one clock; reset is synchronous and active-high
- valid_i  input  1  plaintext/key present; accepted when valid_i && ready_o at a rising edge
- data_i  input  64  plaintext
- key_i  input  KEY_W  cipher key (KEY_W=80; 128 with feature)
- ready_o  output  1  core idle, can accept
- valid_o  output  1  one-cycle pulse, data_o holds new ciphertext
- data_o  output  64  ciphertext, held until next result

Behaviour:
- Reset (synchronous, rst_i=1 at edge):
  - FSM goes to IDLE; state_q, key_q, round_q, data_o = 0; valid_o = 0; ready_o = 1 the cycle after reset.
  - Reset mid-encryption discards the operation; no valid_o is produced.
- FSM states:
  - IDLE: ready_o=1. On accept: state_q <= data_i, key_q <= key_i, round_q <= 1, go to ROUND.
  - ROUND: ready_o=0.
    - Each edge: state_q <= P(S(state_q ^ key_q[KEY_W-1 -: 64])); key_q <= ks(key_q, round_q); round_q++.
    - When round_q == ROUNDS, go to OUT after this update.
  - OUT: ready_o=0. At the edge: data_o <= state_q ^ key_q[KEY_W-1 -: 64]; valid_o <= 1; go to IDLE.
  - valid_o is cleared at every edge where it is not being set, so it is high exactly one cycle.
- Key schedule ks (80-bit), with k the key register and i the round counter:
  - k <= k rotated left by 61.
  - k[79:76] <= S(k[79:76]).
  - k[19:15] ^= i[4:0].
  - round_q is 5 bits; with ROUNDS=31 it counts 1..31 and never wraps.
- Latency: accept edge E0; rounds at E1..E_ROUNDS; valid_o high in the cycle after edge E_(ROUNDS+1), i.e. 32 edges after E0 with the default. Throughput is one block per ROUNDS+2 cycles.
- Handshake details:
  - valid_i while ready_o=0 is ignored; there is no queueing.
  - A new accept can occur in the same cycle valid_o is high: the core is in IDLE then, with ready_o=1.
  - data_i and key_i are sampled only at the accept edge.
- No backpressure on output: the consumer must take data_o while valid_o is high, or later while data_o is held.
- Bit order: bit 63 = MSB; S-box nibble n covers bits [4n+3:4n].
- S-box table (input 0..F): C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2.

Optional Feature:
- Macro: PRESENT_KEY128_EN.
- Defined:
  - KEY_W=128; key_i is 128 bits.
  - ks becomes: rotate left 61; k[127:124] <= S(k[127:124]); k[123:120] <= S(k[123:120]); k[66:62] ^= i[4:0].
  - Round key is k[127:64].
- Undefined: the 80-bit schedule above; key_i is 80 bits.
- Latency and handshake are identical in both modes.

Decomposition:
- Package present_pkg holds:
  - SBOX constant array.
  - KEY_W localparam (selected by the macro).
  - ROUNDS_MAX=31.
  - FSM state enum {IDLE, ROUND, OUT}.
  - sbox4 function (used by the key schedule).
- Sub-module present_sbox_layer: 64-bit combinational, 16 parallel sbox4 instances. Its output is fed to the existing `permutation` module; both are instantiated inside present_enc_iter.

Test Plan:
1. PRESENT-80, pt=0000000000000000, key=0 → valid_o after 32 edges, data_o=5579C1387B228445.
2. pt=0, key=FFFFFFFFFFFFFFFFFFFF → E72C46C0F5945049. pt=FFFFFFFFFFFFFFFF, key=0 → A112FFC72F68417B. pt=all-F, key=all-F → 3333DCD3213210D2.
3. Back-to-back: valid_i held high with two vectors → second accepted in the cycle valid_o of the first is high; both results correct; ready_o low exactly 32 cycles per block.
4. Ignore while busy: change data_i/key_i and pulse valid_i mid-encryption → result unchanged, no extra valid_o.
5. Assert rst_i at round 10 → data_o=0, valid_o stays 0, ready_o=1 next cycle; a subsequent vector (test 1) encrypts correctly.
6. With PRESENT_KEY128_EN: pt=0, key=0 (128-bit) → 96DB702A2E6900AF; repeat test 3 in this mode.

Source files
------------

// File: rtl/present_pkg.sv
// Shared constants, types and S-box helper for the iterative PRESENT core.
// Define PRESENT_KEY128_EN to select the 128-bit key schedule.
package present_pkg;

`ifdef PRESENT_KEY128_EN
    localparam int KEY_W = 128;
`else
    localparam int KEY_W = 80;
`endif

    localparam int ROUNDS_MAX = 31;

    localparam logic [3:0] SBOX [16] = '{
        4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
        4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
    };

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        OUT   = 2'd2
    } fsm_e;

    function automatic logic [3:0] sbox4(input logic [3:0] x);
        return SBOX[x];
    endfunction

endpackage

// File: rtl/permutation.sv
// PRESENT bit permutation: bit i moves to (16*i) mod 63, bit 63 stays put.
module permutation (
    input  logic [63:0] data_i,
    output logic [63:0] data_o
);

    for (genvar i = 0; i < 63; i++) begin : g_perm
        assign data_o[(i*16) % 63] = data_i[i];
    end
    assign data_o[63] = data_i[63];

endmodule

// File: rtl/present_sbox_layer.sv
// PRESENT substitution layer: 16 parallel 4-bit S-boxes over a 64-bit word.
module present_sbox_layer
    import present_pkg::*;
(
    input  logic [63:0] data_i,
    output logic [63:0] data_o
);

    for (genvar n = 0; n < 16; n++) begin : g_sbox
        assign data_o[4*n+3 -: 4] = sbox4(data_i[4*n+3 -: 4]);
    end

endmodule

// File: rtl/present_enc_iter.sv
// Iterative PRESENT encryption core, one round per clock, round keys made on the fly.
// Define PRESENT_KEY128_EN for the 128-bit key variant (default: PRESENT-80).
module present_enc_iter
    import present_pkg::*;
#(
    parameter int ROUNDS = 31
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic [63:0]      data_i,
    input  logic [KEY_W-1:0] key_i,
    output logic             ready_o,
    output logic             valid_o,
    output logic [63:0]      data_o
);

    localparam logic [4:0] LAST_ROUND = 5'(ROUNDS);

    fsm_e             fsm_q, fsm_d;
    logic [63:0]      state_q, state_d;
    logic [KEY_W-1:0] key_q, key_d, key_next;
    logic [4:0]       round_q, round_d;
    logic [63:0]      data_q, data_d;
    logic             valid_q, valid_d;

    logic [63:0] round_key, sbox_out, perm_out;

    assign round_key = key_q[KEY_W-1 -: 64];

    present_sbox_layer u_sbox (
        .data_i (state_q ^ round_key),
        .data_o (sbox_out)
    );

    permutation u_perm (
        .data_i (sbox_out),
        .data_o (perm_out)
    );

    // Key schedule update for the round currently indexed by round_q.
    always_comb begin
`ifdef PRESENT_KEY128_EN
        key_next           = {key_q[66:0], key_q[127:67]};
        key_next[127:124]  = sbox4(key_next[127:124]);
        key_next[123:120]  = sbox4(key_next[123:120]);
        key_next[66:62]    = key_next[66:62] ^ round_q;
`else
        key_next           = {key_q[18:0], key_q[79:19]};
        key_next[79:76]    = sbox4(key_next[79:76]);
        key_next[19:15]    = key_next[19:15] ^ round_q;
`endif
    end

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        key_d   = key_q;
        round_d = round_q;
        data_d  = data_q;
        valid_d = 1'b0;
        case (fsm_q)
            IDLE: begin
                if (valid_i) begin
                    state_d = data_i;
                    key_d   = key_i;
                    round_d = 5'd1;
                    fsm_d   = ROUND;
                end
            end
            ROUND: begin
                state_d = perm_out;
                key_d   = key_next;
                round_d = round_q + 5'd1;
                if (round_q == LAST_ROUND) begin
                    fsm_d = OUT;
                end
            end
            OUT: begin
                // Final whitening uses the key left after the last schedule step.
                data_d  = state_q ^ round_key;
                valid_d = 1'b1;
                fsm_d   = IDLE;
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            key_q   <= '0;
            round_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            key_q   <= key_d;
            round_q <= round_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign ready_o = (fsm_q == IDLE);
    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule
